// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue (wb_queue / wb_fifo).
package wb_pkg;
  localparam int RAW_DEF   = 4;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_MAX = 8;
  localparam logic [3:0] REG_DST = 4'd15;

  typedef struct packed {
    logic [RAW_DEF-1:0] rd;
    logic [DW_DEF-1:0]  data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular writeback store: up to two pushes and one pop per cycle, with
// per-slot valid bits and register tags exposed for hazard lookup.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int RAW   = 4,
  parameter int DW    = 8,
  localparam int CW   = $clog2(DEPTH+1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      push_a,
  input  logic [RAW-1:0]            reg_a,
  input  logic [DW-1:0]             data_a,
  input  logic                      push_b,
  input  logic [RAW-1:0]            reg_b,
  input  logic [DW-1:0]             data_b,
  input  logic                      pop,
  output logic [DEPTH-1:0]          slot_vld,
  output logic [DEPTH-1:0][RAW-1:0] slot_reg,
  output logic [RAW-1:0]            head_reg,
  output logic [DW-1:0]             head_data,
  output logic [CW-1:0]             count
);
  logic [DEPTH-1:0][DW-1:0] slot_data;
  logic [PW-1:0]            wr_ptr, wr_ptr_b, rd_ptr;
  logic [DEPTH-1:0]         vld_next;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_ptr_b  = inc(wr_ptr);
  assign head_reg  = slot_reg[rd_ptr];
  assign head_data = slot_data[rd_ptr];

  always_comb begin
    vld_next = slot_vld;
    if (pop)    vld_next[rd_ptr]   = 1'b0;
    if (push_a) vld_next[wr_ptr]   = 1'b1;
    if (push_b) vld_next[wr_ptr_b] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_vld <= '0;
      slot_reg <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      slot_vld <= vld_next;
      count    <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
      if (pop) rd_ptr <= inc(rd_ptr);
      if (push_b)      wr_ptr <= inc(wr_ptr_b);
      else if (push_a) wr_ptr <= wr_ptr_b;
      if (push_a) slot_reg[wr_ptr]   <= reg_a;
      if (push_b) slot_reg[wr_ptr_b] <= reg_b;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_a) slot_data[wr_ptr]   <= data_a;
    if (push_b) slot_data[wr_ptr_b] <= data_b;
  end
endmodule

// File: rtl/wb_queue.sv
// Writeback queue in front of the register-file write port: load-priority
// admission, in-order drain, hazard report. Optional WB_BYPASS_EN zero-latency path.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RAW   = RAW_DEF,
  parameter int DW    = DW_DEF,
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           alu_valid,
  input  logic [RAW-1:0] alu_reg,
  input  logic [DW-1:0]  alu_data,
  output logic           alu_ready,
  input  logic           mem_valid,
  input  logic [RAW-1:0] mem_reg,
  input  logic [DW-1:0]  mem_data,
  output logic           mem_ready,
  input  logic [RAW-1:0] rd_reg,
  output logic           hazard,
  output logic           dst_pending,
  output logic           wb_we,
  output logic [RAW-1:0] wb_reg,
  output logic [DW-1:0]  wb_data,
  output logic [CW-1:0]  count
);
  logic                      mem_acc, alu_acc, byp_mem, byp_alu;
  logic                      q_mem, q_alu, push_a, push_b, pop;
  logic [RAW-1:0]            reg_a, head_reg;
  logic [DW-1:0]             data_a, head_data;
  logic [DEPTH-1:0]          slot_vld;
  logic [DEPTH-1:0][RAW-1:0] slot_reg;

  // Readiness uses registered occupancy only; this cycle's pop is not credited.
  assign mem_ready = ({1'b0, count} < (CW+1)'(DEPTH));
  assign alu_ready = (({1'b0, count} + (CW+1)'(mem_valid)) < (CW+1)'(DEPTH));
  assign mem_acc   = mem_valid & mem_ready;
  assign alu_acc   = alu_valid & alu_ready;

`ifdef WB_BYPASS_EN
  assign byp_mem = mem_acc & (count == '0);
  assign byp_alu = alu_acc & ~mem_acc & (count == '0);
`else
  assign byp_mem = 1'b0;
  assign byp_alu = 1'b0;
`endif

  // Load goes in first so a same-cycle ALU result lands behind it.
  assign q_mem  = mem_acc & ~byp_mem;
  assign q_alu  = alu_acc & ~byp_alu;
  assign push_a = q_mem | q_alu;
  assign push_b = q_mem & q_alu;
  assign reg_a  = q_mem ? mem_reg  : alu_reg;
  assign data_a = q_mem ? mem_data : alu_data;
  assign pop    = (count != '0);

  wb_fifo #(.DEPTH(DEPTH), .RAW(RAW), .DW(DW)) u_fifo (
    .CLK(CLK), .RST_N(RST_N),
    .push_a(push_a), .reg_a(reg_a), .data_a(data_a),
    .push_b(push_b), .reg_b(alu_reg), .data_b(alu_data),
    .pop(pop),
    .slot_vld(slot_vld), .slot_reg(slot_reg),
    .head_reg(head_reg), .head_data(head_data),
    .count(count)
  );

  always_comb begin
    wb_we   = pop;
    wb_reg  = pop ? head_reg  : '0;
    wb_data = pop ? head_data : '0;
    if (byp_mem) begin
      wb_we = 1'b1; wb_reg = mem_reg; wb_data = mem_data;
    end else if (byp_alu) begin
      wb_we = 1'b1; wb_reg = alu_reg; wb_data = alu_data;
    end
  end

  always_comb begin
    hazard      = 1'b0;
    dst_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i] && slot_reg[i] == rd_reg)         hazard      = 1'b1;
      if (slot_vld[i] && slot_reg[i] == RAW'(REG_DST))  dst_pending = 1'b1;
    end
`ifdef WB_BYPASS_EN
    if ((mem_acc && mem_reg == rd_reg) || (alu_acc && alu_reg == rd_reg))
      hazard = 1'b1;
    if ((mem_acc && mem_reg == RAW'(REG_DST)) || (alu_acc && alu_reg == RAW'(REG_DST)))
      dst_pending = 1'b1;
`endif
  end
endmodule
